// File: rtl/csi2_packet_decoder.sv
// CSI-2 low-level protocol decoder: merges 1/2/4 byte lanes into header events and payload words.
// Optional payload CRC-16 check is built when CSI2_CRC_CHECK_EN is defined.
module csi2_packet_decoder #(
    parameter int unsigned NUM_LANES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*NUM_LANES-1:0] lane_data,
    input  logic [NUM_LANES-1:0]   lane_enable,
    output logic                   lane_reset,
    output logic [31:0]            raw_data,
    output logic                   raw_data_enable,
    output logic                   raw_data_last,
    output logic [1:0]             virtual_channel,
    output logic [5:0]             data_type,
    output logic [15:0]            word_count,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   line_start,
    output logic                   line_end,
    output logic                   header_ecc_error,
    output logic                   crc_error
);

    if (!(NUM_LANES == 1 || NUM_LANES == 2 || NUM_LANES == 4)) begin : g_bad_lanes
        $error("csi2_packet_decoder: NUM_LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StHeader, StPayload, StFooter, StResync} state_e;

    state_e      state_q, state_d;
    logic [1:0]  hcnt_q, hcnt_d;
    logic [23:0] hdr_q, hdr_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] asm_q, asm_d;
    logic [1:0]  acnt_q, acnt_d;
    logic        fcnt_q, fcnt_d;

    logic        take_c;
    logic [7:0]  byte_c;
    logic        emit, emit_last;
    logic [31:0] emit_data;
    logic        hdr_ok, hdr_bad;
    logic [3:0]  evt;

    function automatic logic [5:0] header_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

`ifdef CSI2_CRC_CHECK_EN
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_bad;

    // Reflected CRC-16 (poly 0x1021 -> 0x8408), one byte LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction
`endif

    // Walk the consumed lanes in packet order, advancing the packet state one byte at a time.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        hdr_d     = hdr_q;
        rem_d     = rem_q;
        asm_d     = asm_q;
        acnt_d    = acnt_q;
        fcnt_d    = fcnt_q;
        take_c    = 1'b1;
        byte_c    = 8'h00;
        emit      = 1'b0;
        emit_last = 1'b0;
        emit_data = 32'h0;
        hdr_ok    = 1'b0;
        hdr_bad   = 1'b0;
        evt       = 4'h0;
`ifdef CSI2_CRC_CHECK_EN
        crc_d     = crc_q;
        crc_lo_d  = crc_lo_q;
        crc_bad   = 1'b0;
`endif
        if (state_q == StResync) begin
            state_d = StHeader;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                take_c = take_c & lane_enable[i];
                byte_c = lane_data[8*i +: 8];
                if (take_c) begin
                    case (state_d)
                        StHeader: begin
                            if (hcnt_d == 2'd3) begin
                                hcnt_d  = 2'd0;
                                state_d = StResync;
                                if (byte_c[7:6] != 2'b00 || byte_c[5:0] != header_ecc(hdr_d)) begin
                                    hdr_bad = 1'b1;
                                end else begin
                                    hdr_ok = 1'b1;
                                    if (hdr_d[5:0] <= 6'h0F) begin
                                        if (hdr_d[5:2] == 4'h0) evt[hdr_d[1:0]] = 1'b1;
                                    end else begin
                                        rem_d   = hdr_d[23:8];
                                        asm_d   = 32'h0;
                                        acnt_d  = 2'd0;
                                        fcnt_d  = 1'b0;
                                        state_d = (hdr_d[23:8] == 16'd0) ? StFooter : StPayload;
`ifdef CSI2_CRC_CHECK_EN
                                        crc_d   = 16'hFFFF;
`endif
                                    end
                                end
                            end else begin
                                hdr_d  = {byte_c, hdr_d[23:8]};
                                hcnt_d = hcnt_d + 2'd1;
                            end
                        end
                        StPayload: begin
                            asm_d = asm_d | (32'(byte_c) << (8 * acnt_d));
                            rem_d = rem_d - 16'd1;
`ifdef CSI2_CRC_CHECK_EN
                            crc_d = crc_byte(crc_d, byte_c);
`endif
                            if (rem_d == 16'd0) begin
                                emit      = 1'b1;
                                emit_last = 1'b1;
                                emit_data = asm_d;
                                asm_d     = 32'h0;
                                acnt_d    = 2'd0;
                                state_d   = StFooter;
                            end else if (acnt_d == 2'd3) begin
                                emit      = 1'b1;
                                emit_data = asm_d;
                                asm_d     = 32'h0;
                                acnt_d    = 2'd0;
                            end else begin
                                acnt_d = acnt_d + 2'd1;
                            end
                        end
                        StFooter: begin
                            if (!fcnt_d) begin
                                fcnt_d = 1'b1;
`ifdef CSI2_CRC_CHECK_EN
                                crc_lo_d = byte_c;
`endif
                            end else begin
                                fcnt_d  = 1'b0;
                                state_d = StResync;
`ifdef CSI2_CRC_CHECK_EN
                                crc_bad = ({byte_c, crc_lo_d} != crc_d);
`endif
                            end
                        end
                        default: begin
                            // Bytes after the packet end in this cycle are dropped.
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= StHeader;
            hcnt_q           <= 2'd0;
            hdr_q            <= 24'h0;
            rem_q            <= 16'h0;
            asm_q            <= 32'h0;
            acnt_q           <= 2'd0;
            fcnt_q           <= 1'b0;
            lane_reset       <= 1'b0;
            raw_data         <= 32'h0;
            raw_data_enable  <= 1'b0;
            raw_data_last    <= 1'b0;
            virtual_channel  <= 2'd0;
            data_type        <= 6'd0;
            word_count       <= 16'h0;
            frame_start      <= 1'b0;
            frame_end        <= 1'b0;
            line_start       <= 1'b0;
            line_end         <= 1'b0;
            header_ecc_error <= 1'b0;
        end else begin
            state_q          <= state_d;
            hcnt_q           <= hcnt_d;
            hdr_q            <= hdr_d;
            rem_q            <= rem_d;
            asm_q            <= asm_d;
            acnt_q           <= acnt_d;
            fcnt_q           <= fcnt_d;
            lane_reset       <= (state_d == StResync);
            raw_data_enable  <= emit;
            raw_data_last    <= emit_last;
            if (emit) raw_data <= emit_data;
            if (hdr_ok) begin
                virtual_channel <= hdr_d[7:6];
                data_type       <= hdr_d[5:0];
                word_count      <= hdr_d[23:8];
            end
            frame_start      <= evt[0];
            frame_end        <= evt[1];
            line_start       <= evt[2];
            line_end         <= evt[3];
            header_ecc_error <= hdr_bad;
        end
    end

`ifdef CSI2_CRC_CHECK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            crc_q     <= 16'h0;
            crc_lo_q  <= 8'h0;
            crc_error <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_lo_q  <= crc_lo_d;
            crc_error <= crc_bad;
        end
    end
`else
    assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// Directed self-checking bench for csi2_packet_decoder on 1, 2 and 4 lane instances.
`timescale 1ns/1ps
module tb_csi2_packet_decoder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [15:0] ld2 = '0;
    logic [1:0]  en2 = '0;
    logic        lr2, rde2, rdl2, fs2, fe2, ls2, lne2, ecc2, crc2;
    logic [31:0] rd2;
    logic [1:0]  vc2;
    logic [5:0]  dt2;
    logic [15:0] wc2;

    logic [31:0] ld4 = '0;
    logic [3:0]  en4 = '0;
    logic        lr4, rde4, rdl4, fs4, fe4, ls4, lne4, ecc4, crc4;
    logic [31:0] rd4;
    logic [1:0]  vc4;
    logic [5:0]  dt4;
    logic [15:0] wc4;

    logic [7:0]  ld1 = '0;
    logic        en1 = '0;
    logic        lr1, rde1, rdl1, fs1, fe1, ls1, lne1, ecc1, crc1;
    logic [31:0] rd1;
    logic [1:0]  vc1;
    logic [5:0]  dt1;
    logic [15:0] wc1;

    csi2_packet_decoder #(.NUM_LANES(2)) u_dut2 (
        .clock(clock), .reset(reset), .lane_data(ld2), .lane_enable(en2), .lane_reset(lr2),
        .raw_data(rd2), .raw_data_enable(rde2), .raw_data_last(rdl2), .virtual_channel(vc2),
        .data_type(dt2), .word_count(wc2), .frame_start(fs2), .frame_end(fe2),
        .line_start(ls2), .line_end(lne2), .header_ecc_error(ecc2), .crc_error(crc2)
    );

    csi2_packet_decoder #(.NUM_LANES(4)) u_dut4 (
        .clock(clock), .reset(reset), .lane_data(ld4), .lane_enable(en4), .lane_reset(lr4),
        .raw_data(rd4), .raw_data_enable(rde4), .raw_data_last(rdl4), .virtual_channel(vc4),
        .data_type(dt4), .word_count(wc4), .frame_start(fs4), .frame_end(fe4),
        .line_start(ls4), .line_end(lne4), .header_ecc_error(ecc4), .crc_error(crc4)
    );

    csi2_packet_decoder #(.NUM_LANES(1)) u_dut1 (
        .clock(clock), .reset(reset), .lane_data(ld1), .lane_enable(en1), .lane_reset(lr1),
        .raw_data(rd1), .raw_data_enable(rde1), .raw_data_last(rdl1), .virtual_channel(vc1),
        .data_type(dt1), .word_count(wc1), .frame_start(fs1), .frame_end(fe1),
        .line_start(ls1), .line_end(lne1), .header_ecc_error(ecc1), .crc_error(crc1)
    );

    // Observed traffic, sampled on the falling edge.
    int          ev2[$];
    logic [31:0] words2[$];
    logic        lasts2[$];
    int          lr_cnt2 = 0;
    int          ecc_cnt2 = 0;
    int          stray_last2 = 0;
    logic [31:0] words4[$];
    logic        lasts4[$];
    logic [31:0] words1[$];
    logic        lasts1[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (fs2) ev2.push_back(0);
            if (fe2) ev2.push_back(1);
            if (ls2) ev2.push_back(2);
            if (lne2) ev2.push_back(3);
            if (rde2) begin
                words2.push_back(rd2);
                lasts2.push_back(rdl2);
            end
            if (rdl2 && !rde2) stray_last2++;
            if (lr2) lr_cnt2++;
            if (ecc2) ecc_cnt2++;
            if (rde4) begin
                words4.push_back(rd4);
                lasts4.push_back(rdl4);
            end
            if (rde1) begin
                words1.push_back(rd1);
                lasts1.push_back(rdl1);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] txq[$];

    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

    task automatic push_header(input logic [7:0] di, input logic [15:0] wc);
        txq.push_back(di);
        txq.push_back(wc[7:0]);
        txq.push_back(wc[15:8]);
        txq.push_back({2'b00, ref_ecc({wc, di})});
    endtask

    task automatic drive(input int lanes, input logic [31:0] d, input logic [3:0] e);
        case (lanes)
            1: begin ld1 = d[7:0]; en1 = e[0]; end
            2: begin ld2 = d[15:0]; en2 = e[1:0]; end
            default: begin ld4 = d; en4 = e; end
        endcase
    endtask

    // Sends txq; gap cycles disable lane 0 while upper lanes carry junk that must be ignored.
    task automatic stream(input int lanes, input bit gaps);
        int cyc;
        logic [31:0] d;
        logic [3:0] e;
        cyc = 0;
        while (txq.size() > 0) begin
            @(negedge clock);
            d = '0;
            e = '0;
            if (gaps && (cyc % 3 == 1)) begin
                d = 32'hEEEEEEEE;
                e = 4'b1110;
            end else begin
                for (int i = 0; i < lanes; i++) begin
                    if (txq.size() > 0) begin
                        d[8*i +: 8] = txq.pop_front();
                        e[i] = 1'b1;
                    end
                end
            end
            cyc++;
            drive(lanes, d, e);
        end
        @(negedge clock);
        drive(lanes, '0, '0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({lr2, rd2, rde2, rdl2, vc2, dt2, wc2, fs2, fe2, ls2, lne2, ecc2, crc2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: outputs %h required 0",
                     {lr2, rd2, rde2, rdl2, vc2, dt2, wc2, fs2, fe2, ls2, lne2, ecc2, crc2});
        end
        checks++;
        if ({lr4, rd4, rde4, rdl4, wc4, crc4, lr1, rd1, rde1, wc1} !== '0) begin
            errors++;
            $display("FAIL reset_dut4_dut1: outputs %h required 0",
                     {lr4, rd4, rde4, rdl4, wc4, crc4, lr1, rd1, rde1, wc1});
        end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_short_packets();
        int base, lrb;
        int exp_ev[4];
        exp_ev = '{0, 2, 3, 1};
        base = ev2.size();
        lrb = lr_cnt2;
        push_header(8'h40, 16'h0001);
        stream(2, 1'b0);
        checks++;
        if (fs2 !== 1'b1 || lr2 !== 1'b1) begin
            errors++;
            $display("FAIL fs_latency: frame_start %b lane_reset %b required 1 1", fs2, lr2);
        end
        idle(1);
        checks++;
        if (fs2 !== 1'b0 || lr2 !== 1'b0) begin
            errors++;
            $display("FAIL fs_one_cycle: frame_start %b lane_reset %b required 0 0", fs2, lr2);
        end
        push_header(8'h42, 16'h0001);
        stream(2, 1'b0);
        push_header(8'h43, 16'h0001);
        stream(2, 1'b0);
        push_header(8'h41, 16'h0007);
        stream(2, 1'b0);
        idle(2);
        checks++;
        if (ev2.size() - base !== 4) begin
            errors++;
            $display("FAIL short_event_count: got %0d required 4", ev2.size() - base);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ev2[base+k] !== exp_ev[k]) begin
                    errors++;
                    $display("FAIL short_event_order[%0d]: got %0d required %0d", k, ev2[base+k],
                             exp_ev[k]);
                end
            end
        end
        checks++;
        if (vc2 !== 2'd1 || dt2 !== 6'h01 || wc2 !== 16'h0007) begin
            errors++;
            $display("FAIL short_fields: vc %0d dt %h wc %h required 1 01 0007", vc2, dt2, wc2);
        end
        checks++;
        if (lr_cnt2 - lrb !== 4) begin
            errors++;
            $display("FAIL short_lane_reset_count: got %0d required 4", lr_cnt2 - lrb);
        end
    endtask

    task automatic test_ecc_error();
        int base, eb;
        base = ev2.size();
        eb = ecc_cnt2;
        txq.push_back(8'h42);
        txq.push_back(8'h23 ^ 8'h04);
        txq.push_back(8'h01);
        txq.push_back({2'b00, ref_ecc(24'h012342)});
        stream(2, 1'b0);
        checks++;
        if (ecc2 !== 1'b1 || lr2 !== 1'b1 || ls2 !== 1'b0) begin
            errors++;
            $display("FAIL ecc_pulse: ecc %b lane_reset %b line_start %b required 1 1 0",
                     ecc2, lr2, ls2);
        end
        idle(2);
        checks++;
        if (wc2 !== 16'h0007 || dt2 !== 6'h01 || ev2.size() !== base) begin
            errors++;
            $display("FAIL ecc_retain: wc %h dt %h events %0d required 0007 01 %0d",
                     wc2, dt2, ev2.size(), base);
        end
        checks++;
        if (ecc_cnt2 - eb !== 1) begin
            errors++;
            $display("FAIL ecc_count: got %0d required 1", ecc_cnt2 - eb);
        end
    endtask

    task automatic test_long_partial();
        int base;
        base = words2.size();
        push_header(8'h2A, 16'd6);
        for (int k = 1; k <= 6; k++) txq.push_back(8'(k));
        txq.push_back(8'h00);
        txq.push_back(8'h00);
        stream(2, 1'b0);
        checks++;
        if (lr2 !== 1'b1) begin
            errors++;
            $display("FAIL long_lane_reset: got %b required 1", lr2);
        end
        idle(2);
        checks++;
        if (words2.size() - base !== 2) begin
            errors++;
            $display("FAIL long_strobes: got %0d required 2", words2.size() - base);
        end else begin
            checks++;
            if (words2[base] !== 32'h04030201 || lasts2[base] !== 1'b0) begin
                errors++;
                $display("FAIL long_word0: got %h last %b required 04030201 0", words2[base],
                         lasts2[base]);
            end
            checks++;
            if (words2[base+1] !== 32'h00000605 || lasts2[base+1] !== 1'b1) begin
                errors++;
                $display("FAIL long_word1: got %h last %b required 00000605 1", words2[base+1],
                         lasts2[base+1]);
            end
        end
        checks++;
        if (dt2 !== 6'h2A || wc2 !== 16'd6 || vc2 !== 2'd0) begin
            errors++;
            $display("FAIL long_fields: dt %h wc %h vc %0d required 2a 0006 0", dt2, wc2, vc2);
        end
    endtask

    task automatic test_wc_zero();
        int base;
        base = words2.size();
        push_header(8'h2A, 16'd0);
        txq.push_back(8'h12);
        txq.push_back(8'h34);
        stream(2, 1'b0);
        checks++;
        if (lr2 !== 1'b1) begin
            errors++;
            $display("FAIL wc0_lane_reset: got %b required 1", lr2);
        end
        idle(2);
        checks++;
        if (words2.size() !== base || wc2 !== 16'd0) begin
            errors++;
            $display("FAIL wc0_no_strobe: strobes %0d wc %h required 0 0000", words2.size() - base,
                     wc2);
        end
    endtask

    task automatic test_gaps();
        int b2, b1;
        logic [31:0] exp_w[2];
        exp_w = '{32'h14131211, 32'h00171615};
        b2 = words2.size();
        b1 = words1.size();
        for (int run = 0; run < 3; run++) begin
            push_header(8'h2A, 16'd7);
            for (int k = 0; k < 7; k++) txq.push_back(8'h11 + 8'(k));
            txq.push_back(8'hAB);
            txq.push_back(8'hCD);
            if (run == 0) stream(2, 1'b1);
            else stream(1, run == 2);
            idle(2);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (words2.size() !== b2 + 2 || words2[b2+k] !== exp_w[k] || lasts2[b2+k] !== (k == 1)) begin
                errors++;
                $display("FAIL gap2_word%0d: got %h required %h", k, words2[b2+k], exp_w[k]);
            end
            for (int r = 0; r < 2; r++) begin
                checks++;
                if (words1.size() !== b1 + 4 || words1[b1+2*r+k] !== exp_w[k]
                        || lasts1[b1+2*r+k] !== (k == 1)) begin
                    errors++;
                    $display("FAIL lane1_run%0d_word%0d: got %h required %h", r, k,
                             words1[b1+2*r+k], exp_w[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base, eb;
        base = ev2.size();
        eb = ecc_cnt2;
        push_header(8'h40, 16'd2);
        txq.push_back(8'hEE);
        txq.push_back(8'hEE);
        push_header(8'h42, 16'd3);
        stream(2, 1'b0);
        idle(2);
        checks++;
        if (ev2.size() !== base + 2 || ev2[base] !== 0 || ev2[base+1] !== 2 || wc2 !== 16'd3
                || ecc_cnt2 !== eb) begin
            errors++;
            $display("FAIL back_to_back: events %0d wc %h ecc %0d required 2 0003 0",
                     ev2.size() - base, wc2, ecc_cnt2 - eb);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        push_header(8'h2A, 16'd8);
        txq.push_back(8'h01);
        txq.push_back(8'h02);
        txq.push_back(8'h03);
        stream(2, 1'b0);
        checks++;
        if (wc2 !== 16'd8) begin
            errors++;
            $display("FAIL mid_precondition_wc: got %h required 0008", wc2);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({lr2, rd2, rde2, rdl2, vc2, dt2, wc2, fs2, fe2, ls2, lne2, ecc2, crc2} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h required 0",
                     {lr2, rd2, rde2, rdl2, vc2, dt2, wc2, fs2, fe2, ls2, lne2, ecc2, crc2});
        end
        @(negedge clock);
        reset = 1'b0;
        base = words2.size();
        push_header(8'h2A, 16'd4);
        txq.push_back(8'hAA);
        txq.push_back(8'hBB);
        txq.push_back(8'hCC);
        txq.push_back(8'hDD);
        txq.push_back(8'h00);
        txq.push_back(8'h00);
        stream(2, 1'b0);
        idle(2);
        checks++;
        if (words2.size() !== base + 1 || words2[base] !== 32'hDDCCBBAA || lasts2[base] !== 1'b1
                || wc2 !== 16'd4) begin
            errors++;
            $display("FAIL mid_after_reset: strobes %0d word %h wc %h required 1 ddccbbaa 0004",
                     words2.size() - base, words2[base], wc2);
        end
    endtask

    task automatic test_known_header();
        int base, eb;
        base = words2.size();
        eb = ecc_cnt2;
        txq.push_back(8'h37);
        txq.push_back(8'hF0);
        txq.push_back(8'h01);
        txq.push_back(8'h3F);
        for (int k = 0; k < 496; k++) txq.push_back(8'(k));
        txq.push_back(8'h00);
        txq.push_back(8'h00);
        stream(2, 1'b0);
        idle(2);
        checks++;
        if (ecc_cnt2 !== eb || dt2 !== 6'h37 || wc2 !== 16'h01F0 || words2.size() !== base + 124
                || words2[base+123] !== 32'hEFEEEDEC || lasts2[base+123] !== 1'b1) begin
            errors++;
            $display("FAIL known_header: ecc %0d dt %h wc %h strobes %0d required 0 37 01f0 124",
                     ecc_cnt2 - eb, dt2, wc2, words2.size() - base);
        end
        checks++;
        if (stray_last2 !== 0) begin
            errors++;
            $display("FAIL stray_last: got %0d required 0", stray_last2);
        end
    endtask

    task automatic test_crc();
        logic [7:0] pay[24];
        logic [7:0] foot;
        int base;
        pay = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8,
                8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00,
                8'h00, 8'h01};
        for (int run = 0; run < 2; run++) begin
            base = words4.size();
            foot = (run == 0) ? 8'hF0 : 8'hF1;
            push_header(8'h2A, 16'd24);
            for (int k = 0; k < 24; k++) txq.push_back(pay[k]);
            txq.push_back(foot);
            txq.push_back(8'h00);
            stream(4, 1'b0);
            checks++;
`ifdef CSI2_CRC_CHECK_EN
            if (crc4 !== (run == 1) || lr4 !== 1'b1) begin
                errors++;
                $display("FAIL crc_run%0d: crc_error %b lane_reset %b required %0d 1", run, crc4,
                         lr4, run);
            end
`else
            if (crc4 !== 1'b0 || lr4 !== 1'b1) begin
                errors++;
                $display("FAIL crc_tied_run%0d: crc_error %b lane_reset %b required 0 1", run,
                         crc4, lr4);
            end
`endif
            idle(2);
            checks++;
            if (words4.size() !== base + 6 || words4[base] !== 32'h020000FF
                    || words4[base+5] !== 32'h010000FF || lasts4[base+5] !== 1'b1) begin
                errors++;
                $display("FAIL crc_words_run%0d: strobes %0d first %h last %h required 6 020000ff 010000ff",
                         run, words4.size() - base, words4[base], words4[base+5]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_packets();
        test_ecc_error();
        test_long_partial();
        test_wc_zero();
        test_gaps();
        test_back_to_back();
        test_known_header();
        test_crc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
